// File: rtl/pad_glitch_filter.sv
// pad_glitch_filter: multi-channel pad conditioner.
// Each channel: two-flop synchroniser, optional counter-based glitch filter,
// registered rise/fall strobes.
//
// Build option: define PAD_GLITCH_FILTER_EN to enable the counter filter
// (FILT_LEN honoured). Without it, PAD_OUT is the synchronised level
// registered once and FILT_LEN is ignored.
//
// Ports:
//   CLK       block clock, rising edge
//   RST_N     asynchronous active-low reset
//   PAD_IN    raw asynchronous pad levels (NCH)
//   FILT_LEN  rejection window in CLK cycles, 0 behaves as 1 (CW)
//   PAD_OUT   filtered level per channel, registered (NCH)
//   PAD_RISE  one-cycle strobe with a PAD_OUT 0->1 transition (NCH)
//   PAD_FALL  one-cycle strobe with a PAD_OUT 1->0 transition (NCH)
module pad_glitch_filter #(
  parameter int unsigned    NCH     = 2,
  parameter int unsigned    CW      = 4,
  parameter logic [NCH-1:0] RST_VAL = {NCH{1'b1}}
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic [NCH-1:0] PAD_IN,
  input  logic [CW-1:0]  FILT_LEN,
  output logic [NCH-1:0] PAD_OUT,
  output logic [NCH-1:0] PAD_RISE,
  output logic [NCH-1:0] PAD_FALL
);

  localparam int unsigned CNT_W = CW + 1;

  logic [NCH-1:0] s1_q;
  logic [NCH-1:0] s2_q;
  logic [NCH-1:0] out_d;
  logic [NCH-1:0] rise_d;
  logic [NCH-1:0] fall_d;

  // Two-flop synchroniser per channel.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= PAD_IN;
      s2_q <= s1_q;
    end
  end

`ifdef PAD_GLITCH_FILTER_EN
  logic [CW-1:0]    cnt_q [NCH];
  logic [CW-1:0]    cnt_d [NCH];
  logic [CNT_W-1:0] len_eff;

  // Zero length is treated as one; compare is one bit wider so cnt+1 never wraps.
  always_comb begin
    len_eff = (FILT_LEN == '0) ? CNT_W'(1) : CNT_W'(FILT_LEN);
  end

  // Accept s2 only after it has disagreed with PAD_OUT for len_eff samples.
  always_comb begin
    out_d  = PAD_OUT;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != PAD_OUT[i]) begin
        if ((CNT_W'(cnt_q[i]) + CNT_W'(1)) >= len_eff) begin
          out_d[i]  = s2_q[i];
          rise_d[i] = s2_q[i];
          fall_d[i] = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Per-channel disagreement counters.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < int'(NCH); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NCH); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
`else
  logic [CW-1:0] unused_filt_len;
  assign unused_filt_len = FILT_LEN;

  // No filtering: follow s2 one cycle later.
  always_comb begin
    out_d  = s2_q;
    rise_d = s2_q & ~PAD_OUT;
    fall_d = ~s2_q & PAD_OUT;
  end
`endif

  // Registered outputs; strobes coincide with the new PAD_OUT level.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PAD_OUT  <= RST_VAL;
      PAD_RISE <= '0;
      PAD_FALL <= '0;
    end else begin
      PAD_OUT  <= out_d;
      PAD_RISE <= rise_d;
      PAD_FALL <= fall_d;
    end
  end

endmodule

// File: tb/tb_pad_glitch_filter.sv
// Bench for pad_glitch_filter: directed scenarios plus random pad activity,
// checked every cycle against a sample-history reference model.
module tb_pad_glitch_filter;

  localparam int unsigned    NCH     = 2;
  localparam int unsigned    CW      = 4;
  localparam logic [NCH-1:0] RST_VAL = '1;
`ifdef PAD_GLITCH_FILTER_EN
  localparam bit FILTER_ON = 1'b1;
`else
  localparam bit FILTER_ON = 1'b0;
`endif

  logic           CLK = 1'b0;
  logic           RST_N;
  logic [NCH-1:0] PAD_IN;
  logic [CW-1:0]  FILT_LEN;
  logic [NCH-1:0] PAD_OUT;
  logic [NCH-1:0] PAD_RISE;
  logic [NCH-1:0] PAD_FALL;

  always #5 CLK = ~CLK;

  pad_glitch_filter #(.NCH(NCH), .CW(CW), .RST_VAL(RST_VAL)) dut (
    .CLK(CLK), .RST_N(RST_N), .PAD_IN(PAD_IN), .FILT_LEN(FILT_LEN),
    .PAD_OUT(PAD_OUT), .PAD_RISE(PAD_RISE), .PAD_FALL(PAD_FALL)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: synchroniser pipe plus history of s2 samples since reset.
  logic [NCH-1:0] m_s1, m_s2, m_out, m_rise, m_fall;
  logic [NCH-1:0] hist[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = RST_VAL; m_s2 = RST_VAL; m_out = RST_VAL;
    m_rise = '0; m_fall = '0;
    hist.delete();
  endtask

  // A channel changes once its most recent L s2 samples all disagree with the output.
  task automatic model_edge();
    int len;
    len = FILTER_ON ? ((FILT_LEN == '0) ? 1 : int'(FILT_LEN)) : 1;
    hist.push_back(m_s2);
    if (hist.size() > 20) void'(hist.pop_front());
    m_rise = '0; m_fall = '0;
    for (int ch = 0; ch < int'(NCH); ch++) begin
      int run = 0;
      for (int k = hist.size() - 1; k >= 0; k--) begin
        logic [NCH-1:0] h = hist[k];
        if (h[ch] != m_out[ch]) run++;
        else break;
      end
      if (run >= len) begin
        m_out[ch] = m_s2[ch];
        if (m_s2[ch]) m_rise[ch] = 1'b1;
        else          m_fall[ch] = 1'b1;
      end
    end
    m_s2 = m_s1;
    m_s1 = PAD_IN;
  endtask

  // One clock: model follows the edge, outputs compared 1 ns later, return at negedge.
  task automatic cycle(input string tag);
    @(posedge CLK);
    if (!RST_N) model_reset();
    else        model_edge();
    #1;
    check({tag, "_out"},  PAD_OUT,  m_out);
    check({tag, "_rise"}, PAD_RISE, m_rise);
    check({tag, "_fall"}, PAD_FALL, m_fall);
    @(negedge CLK);
  endtask

  task automatic settle(input int n);
    for (int k = 0; k < n; k++) cycle("settle");
  endtask

  // Cycles until PAD_OUT[ch] reaches val; -1 if the bound expires.
  task automatic wait_bit(input int ch, input logic val, input int limit, output int lat);
    lat = -1;
    for (int k = 1; k <= limit; k++) begin
      cycle("lat");
      if (PAD_OUT[ch] == val) begin
        lat = k;
        break;
      end
    end
  endtask

  // Assert reset between edges, check immediate effect, hold one edge, release.
  task automatic async_reset(input string tag);
    #2 RST_N = 1'b0;
    #1;
    model_reset();
    check({tag, "_async_out"},  PAD_OUT,  RST_VAL);
    check({tag, "_async_rise"}, PAD_RISE, '0);
    check({tag, "_async_fall"}, PAD_FALL, '0);
    @(negedge CLK);
    cycle(tag);
    RST_N = 1'b1;
  endtask

  initial begin
    int lat;
    int pulses;

    // Reset with pads low: outputs idle high, then fall after release.
    RST_N = 1'b0; PAD_IN = '0; FILT_LEN = '0;
    model_reset();
    repeat (3) @(negedge CLK);
    check("rst_out",  PAD_OUT,  2'b11);
    check("rst_rise", PAD_RISE, 2'b00);
    check("rst_fall", PAD_FALL, 2'b00);
    RST_N = 1'b1;
    wait_bit(0, 1'b0, 10, lat);
    check("rel_lat", lat, 3);
    check("rel_fall", PAD_FALL, 2'b11);
    check("rel_out", PAD_OUT, 2'b00);
    settle(3);

    // Glitch reject: 4-cycle low pulse with window 5.
    FILT_LEN = 4'd5; PAD_IN = 2'b11;
    settle(10);
    PAD_IN[0] = 1'b0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin cycle("glitch"); pulses += int'(PAD_FALL[0]); end
    PAD_IN[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin cycle("glitch"); pulses += int'(PAD_FALL[0]); end
    check("glitch_fall_cnt", pulses, FILTER_ON ? 0 : 1);
    check("glitch_out", PAD_OUT, 2'b11);

    // Accept: held low, then high again; latency 2+L.
    PAD_IN[0] = 1'b0;
    wait_bit(0, 1'b0, 40, lat);
    check("acc_fall_lat", lat, FILTER_ON ? 7 : 3);
    check("acc_fall_pulse", PAD_FALL, 2'b01);
    settle(4);
    PAD_IN[0] = 1'b1;
    wait_bit(0, 1'b1, 40, lat);
    check("acc_rise_lat", lat, FILTER_ON ? 7 : 3);
    check("acc_rise_pulse", PAD_RISE, 2'b01);
    settle(4);

    // Independence: both channels drop, ch1 only for 2 cycles.
    FILT_LEN = 4'd3;
    settle(2);
    PAD_IN = 2'b00;
    pulses = 0;
    for (int k = 0; k < 2; k++) begin cycle("indep"); pulses += int'(PAD_FALL[1]); end
    PAD_IN[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin cycle("indep"); pulses += int'(PAD_FALL[1]); end
    check("indep_ch1_fall_cnt", pulses, FILTER_ON ? 0 : 1);
    check("indep_out", PAD_OUT, 2'b10);

    // Mid-count length reduction: window 10, 4 mismatch samples, then 2.
    FILT_LEN = 4'd10; PAD_IN = 2'b11;
    settle(14);
    PAD_IN[0] = 1'b0;
    for (int k = 0; k < 6; k++) cycle("mid");
    check("mid_before", PAD_OUT[0], FILTER_ON ? 1'b1 : 1'b0);
    FILT_LEN = 4'd2;
    cycle("mid");
    check("mid_after", PAD_OUT[0], 1'b0);
    check("mid_fall", PAD_FALL[0], FILTER_ON ? 1'b1 : 1'b0);

    // Reset mid-count: window 8, reset after 5 mismatch samples.
    FILT_LEN = 4'd8; PAD_IN = 2'b11;
    settle(14);
    PAD_IN[0] = 1'b0;
    for (int k = 0; k < 7; k++) cycle("rstmid");
    async_reset("rstmid");
    wait_bit(0, 1'b0, 40, lat);
    check("rstmid_restart_lat", lat, FILTER_ON ? 10 : 3);
    settle(3);

    // Random pad activity, window changes and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      for (int ch = 0; ch < int'(NCH); ch++) begin
        if ($urandom_range(0, 7) == 0) PAD_IN[ch] = ~PAD_IN[ch];
      end
      if ($urandom_range(0, 49) == 0) FILT_LEN = CW'($urandom_range(0, 15));
      if ($urandom_range(0, 399) == 0) async_reset("rnd");
      else                             cycle("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pad_glitch_filter.md
# pad_glitch_filter

Parametrised, multi-channel input conditioner for slow serial pads (I2C SCL/SDA and similar). Each channel gets a two-flop synchroniser and a counter-based digital glitch filter with a runtime-programmable rejection window. Each channel also produces registered rise and fall strobes. The block sits between the pad ring and the protocol controllers, replacing the per-pin analog-delay filter with a synchronous, clock-counted one.

## Interface
Parameters:
- NCH, 2: number of independent channels.
- CW, 4: width of the filter-length control and of each channel counter.
- RST_VAL, {NCH{1'b1}}: per-channel reset/idle level of the synchroniser, PAD_OUT and the previous-state register. Default is high, for open-drain idle.

Ports:
- CLK  input  1  block clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset. Assertion is asynchronous; deassertion is externally synchronised to CLK.
- PAD_IN  input  NCH  raw asynchronous pad levels.
- FILT_LEN  input  CW  rejection window in CLK cycles, shared by all channels; quasi-static.
- PAD_OUT  output  NCH  filtered level per channel, registered.
- PAD_RISE  output  NCH  one-cycle strobe coincident with a PAD_OUT 0→1 transition.
- PAD_FALL  output  NCH  one-cycle strobe coincident with a PAD_OUT 1→0 transition.

## Operation
- Per channel, the synchroniser path is PAD_IN → s1 → s2, two flops, reset to RST_VAL[i].
- Per channel, cnt is a CW-bit counter that resets to 0.
- The effective length is L = max(FILT_LEN, 1); a FILT_LEN of 0 behaves as 1.
- Each clock, per channel:
  - s2 == PAD_OUT: cnt ← 0; no strobe.
  - s2 != PAD_OUT and cnt+1 ≥ L: PAD_OUT ← s2; cnt ← 0; PAD_RISE or PAD_FALL pulses for this cycle, per the new level.
  - Otherwise: cnt ← cnt+1.
- The comparison is done in CW+1 bits, so cnt+1 never wraps.
- A level that disagrees with PAD_OUT for fewer than L consecutive s2 samples is discarded; any agreeing sample restarts the count.
- Channels are fully independent. Simultaneous transitions on several channels update in the same cycle.
- Lowering FILT_LEN mid-count below the current cnt+1 makes the pending change take effect on the next clock. Raising it extends the pending window; no counts are lost.
- Reset asserted mid-count:
  - s1, s2 and PAD_OUT go immediately to RST_VAL.
  - cnt goes to 0.
  - Strobes go to 0.
  - No strobe is generated on reset entry or exit.
- Reset values: PAD_OUT = RST_VAL, PAD_RISE = 0, PAD_FALL = 0.

## Timing
- Synchroniser latency is 2 cycles from PAD_IN sampling to s2.
- Filtered latency: PAD_OUT changes on the L-th rising edge after s2 first differs. Total latency from the pad edge is 2+L cycles, with +1 cycle sampling uncertainty.
- With L = 1, PAD_OUT is s2 delayed by one cycle, and there is no rejection.
- Minimum accepted pulse width is L cycles at s2. Pulses of L−1 cycles or fewer never reach PAD_OUT.
- Strobes are registered, high for exactly one cycle, and asserted in the same cycle PAD_OUT takes the new value. PAD_RISE and PAD_FALL are never both high on one channel.

## Configuration
- Macro: PAD_GLITCH_FILTER_EN.
- Defined: counter filter as described above; FILT_LEN is honoured.
- Not defined:
  - Counters are removed and FILT_LEN is ignored.
  - PAD_OUT = s2 registered once, giving a fixed 3-cycle latency with no rejection.
  - Strobes are still generated from PAD_OUT transitions.
  - Reset behaviour is unchanged.

## Test plan
- Reset: hold RST_N=0 with PAD_IN=2'b00 and RST_VAL default. Required: PAD_OUT=2'b11, strobes 0. Release reset. Required: PAD_OUT falls 3 cycles later with L=1 and a single PAD_FALL pulse per channel.
- Glitch reject: FILT_LEN=5 (50 ns at 100 MHz); pulse PAD_IN[0] low for 4 cycles. Required: PAD_OUT[0] stays 1, no PAD_FALL.
- Accept: FILT_LEN=5; drive PAD_IN[0] low and hold. Required: PAD_OUT[0]=0 exactly 7 cycles after the edge (±1), with one PAD_FALL pulse. Return it high. Required: one PAD_RISE pulse after 7 cycles.
- Independence: FILT_LEN=3; toggle ch0 and ch1 on the same cycle, ch1 for only 2 cycles. Required: only ch0 changes.
- Mid-count change: FILT_LEN=10; hold a change for 4 cycles, then set FILT_LEN=2. Required: PAD_OUT updates on the next clock.
- Reset mid-count: FILT_LEN=8; assert RST_N after 5 mismatch cycles. Required: PAD_OUT back to RST_VAL immediately, no strobes. After release, the count restarts from 0.
